// File: rtl/ddr3_rd_gearbox.sv
// ---------------------------------------------------------------------------
// ddr3_rd_gearbox
//
// Purpose:
//   Read-data gearbox sitting right behind the DDR3 PHY read path. DFI read
//   beats of 2*DDR3_WIDTH bits are packed into WORD_BITS-wide BL8 words and
//   buffered in a small first-word-fall-through FIFO that feeds the AXI4
//   read-response logic through a valid/ready stream. The PHY cannot be
//   stalled, so dropped words (FIFO full) and bursts ending mid-word are
//   reported through sticky error flags instead of back-pressure.
//
// Ports:
//   clock        system clock (PHY clock domain)
//   reset_n      synchronous, active-low reset
//   dfi_rvld_i   DFI read beat valid
//   dfi_last_i   last beat of the read burst sequence (qualified by dfi_rvld_i)
//   dfi_data_i   DFI read beat data
//   rd_valid_o   output word valid
//   rd_ready_i   output word accepted when rd_valid_o & rd_ready_i
//   rd_last_o    word carried the dfi_last_i beat
//   rd_data_o    assembled word, beat k in bits [k*2W +: 2W]
//   fifo_level_o number of words held in the FIFO (0..FIFO_DEPTH)
//   overflow_o   sticky: a completed word was dropped because the FIFO was full
//   frag_err_o   sticky: dfi_last_i arrived before a word was complete
//   clr_err_i    clears both sticky flags (a same-cycle set event wins)
// ---------------------------------------------------------------------------
module ddr3_rd_gearbox #(
    parameter int DDR3_WIDTH = 16,
    parameter int WORD_BITS  = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int LBITS      = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    dfi_rvld_i,
    input  logic                    dfi_last_i,
    input  logic [2*DDR3_WIDTH-1:0] dfi_data_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic                    rd_last_o,
    output logic [WORD_BITS-1:0]    rd_data_o,
    output logic [LBITS-1:0]        fifo_level_o,
    output logic                    overflow_o,
    output logic                    frag_err_o,
    input  logic                    clr_err_i
);

    localparam int BEAT_BITS = 2 * DDR3_WIDTH;
    localparam int BEATS     = WORD_BITS / BEAT_BITS;
    localparam int BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW        = AW + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    // ---------------------------------------------------------------------
    // Beat assembly
    // ---------------------------------------------------------------------
    logic [BCW-1:0]       bcnt_reg;
    logic [BCW-1:0]       bcnt_next;
    logic                 beat_final;
    logic                 frag_hit;
    logic [WORD_BITS-1:0] word_full;

    assign beat_final = dfi_rvld_i && (bcnt_reg == LAST_BEAT);
    assign frag_hit   = dfi_rvld_i && dfi_last_i && !beat_final;

    always_comb begin
        bcnt_next = bcnt_reg;
        if (beat_final || frag_hit) begin
            bcnt_next = '0;
        end else if (dfi_rvld_i) begin
            bcnt_next = bcnt_reg + BCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bcnt_reg <= '0;
        end else begin
            bcnt_reg <= bcnt_next;
        end
    end

    // Lanes 0..BEATS-2 are held in registers. The final lane is taken straight
    // from the bus, so the completed word is pushed on the same edge that
    // captures its last beat and back-to-back words need no idle gap.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : gen_lane
            if (gi == BEATS - 1) begin : gen_bus_lane
                assign word_full[gi*BEAT_BITS +: BEAT_BITS] = dfi_data_i;
            end else begin : gen_reg_lane
                logic [BEAT_BITS-1:0] lane_reg;

                always_ff @(posedge clock) begin
                    if (!reset_n) begin
                        lane_reg <= '0;
                    end else if (dfi_rvld_i && (bcnt_reg == BCW'(gi))) begin
                        lane_reg <= dfi_data_i;
                    end
                end

                assign word_full[gi*BEAT_BITS +: BEAT_BITS] = lane_reg;
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Word FIFO: pointers carry one extra MSB to tell full from empty.
    // ---------------------------------------------------------------------
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [PW-1:0]      wr_ptr_next;
    logic [PW-1:0]      rd_ptr_next;
    logic [PW-1:0]      level;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic               ovf_set;
    logic [WORD_BITS:0] mem [FIFO_DEPTH];
    logic [WORD_BITS:0] dout_reg;
    logic [WORD_BITS:0] push_entry;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    assign push       = beat_final;
    assign pop        = !empty && rd_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = push && (!full || pop);
    assign ovf_set    = push && full && !pop;
    assign push_entry = {dfi_last_i, word_full};

    assign wr_ptr_next = push_ok ? (wr_ptr_reg + PW'(1)) : wr_ptr_reg;
    assign rd_ptr_next = pop     ? (rd_ptr_reg + PW'(1)) : rd_ptr_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage array without reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

    // Registered read of the entry that will be at the head next cycle. When
    // the word being written is itself the next head (FIFO empty after this
    // cycle's pop), the write data is forwarded because the array read would
    // still return the old contents.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dout_reg <= '0;
        end else if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
            dout_reg <= push_entry;
        end else begin
            dout_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    // Head register holds stale data while empty, so the outputs are masked.
    assign rd_valid_o   = !empty;
    assign rd_data_o    = empty ? '0 : dout_reg[WORD_BITS-1:0];
    assign rd_last_o    = !empty && dout_reg[WORD_BITS];
    assign fifo_level_o = LBITS'(level);

    // ---------------------------------------------------------------------
    // Sticky error flags: a set event in the clearing cycle takes priority.
    // ---------------------------------------------------------------------
    logic ovf_reg;
    logic ovf_next;
    logic frag_reg;
    logic frag_next;

    assign ovf_next  = ovf_set  || (ovf_reg  && !clr_err_i);
    assign frag_next = frag_hit || (frag_reg && !clr_err_i);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovf_reg  <= 1'b0;
            frag_reg <= 1'b0;
        end else begin
            ovf_reg  <= ovf_next;
            frag_reg <= frag_next;
        end
    end

    assign overflow_o = ovf_reg;
    assign frag_err_o = frag_reg;

endmodule

// File: tb/tb_ddr3_rd_gearbox.sv
// ---------------------------------------------------------------------------
// tb_ddr3_rd_gearbox
//
// Self-checking bench for ddr3_rd_gearbox (DDR3_WIDTH=16, WORD_BITS=128,
// FIFO_DEPTH=4). Every cycle the DUT is compared with a queue-based model:
// beats collect in a queue until four are present, words sit in a queue of
// at most four entries, and the sticky flags follow the set/clear rules.
// A vector table covers the basic word and two-word cases; hand-written
// sequences cover overflow, full push+pop, fragments and reset; a random
// phase follows. One line is printed per word handed over on the stream.
// ---------------------------------------------------------------------------
module tb_ddr3_rd_gearbox;

    localparam int BEATS = 4;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         dfi_rvld_i = 1'b0;
    logic         dfi_last_i = 1'b0;
    logic [31:0]  dfi_data_i = '0;
    logic         rd_valid_o;
    logic         rd_ready_i = 1'b0;
    logic         rd_last_o;
    logic [127:0] rd_data_o;
    logic [2:0]   fifo_level_o;
    logic         overflow_o;
    logic         frag_err_o;
    logic         clr_err_i = 1'b0;

    ddr3_rd_gearbox #(
        .DDR3_WIDTH(16),
        .WORD_BITS (128),
        .FIFO_DEPTH(4),
        .LBITS     (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dfi_rvld_i  (dfi_rvld_i),
        .dfi_last_i  (dfi_last_i),
        .dfi_data_i  (dfi_data_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_last_o   (rd_last_o),
        .rd_data_o   (rd_data_o),
        .fifo_level_o(fifo_level_o),
        .overflow_o  (overflow_o),
        .frag_err_o  (frag_err_o),
        .clr_err_i   (clr_err_i)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic         last;
        logic [127:0] data;
    } mword_t;

    logic [31:0] m_part[$];
    mword_t      m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_frag = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model, then compares #1 after the edge.
    task automatic step(input logic rv, input logic lst, input logic [31:0] d,
                        input logic rdy, input logic clr);
        logic         do_pop;
        logic         ovf_set;
        logic         frag_set;
        logic [127:0] w;
        mword_t       e;
        dfi_rvld_i = rv;
        dfi_last_i = lst;
        dfi_data_i = d;
        rd_ready_i = rdy;
        clr_err_i  = clr;
        do_pop = (m_q.size() != 0) && rdy;
        if (!reset_n) begin
            m_q.delete();
            m_part.delete();
            m_ovf  = 1'b0;
            m_frag = 1'b0;
        end else begin
            ovf_set  = 1'b0;
            frag_set = 1'b0;
            if (do_pop) begin
                $display("pop  last=%0d data=%h", m_q[0].last, m_q[0].data);
                m_q.delete(0);
            end
            if (rv) begin
                m_part.push_back(d);
                if (m_part.size() == BEATS) begin
                    for (int k = 0; k < BEATS; k++) w[k*32 +: 32] = m_part[k];
                    e.last = lst;
                    e.data = w;
                    if (m_q.size() < DEPTH) m_q.push_back(e);
                    else ovf_set = 1'b1;
                    m_part.delete();
                end else if (lst) begin
                    m_part.delete();
                    frag_set = 1'b1;
                end
            end
            m_ovf  = ovf_set  || (m_ovf  && !clr);
            m_frag = frag_set || (m_frag && !clr);
        end
        @(posedge clock);
        #1;
        chk("valid", 128'(rd_valid_o), 128'(m_q.size() != 0));
        chk("level", 128'(fifo_level_o), 128'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("data", rd_data_o, m_q[0].data);
            chk("last", 128'(rd_last_o), 128'(m_q[0].last));
        end
        chk("overflow", 128'(overflow_o), 128'(m_ovf));
        chk("frag_err", 128'(frag_err_o), 128'(m_frag));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_valid", 128'(rd_valid_o), 128'(0));
        chk("rst_level", 128'(fifo_level_o), 128'(0));
        chk("rst_data", rd_data_o, 128'(0));
        chk("rst_last", 128'(rd_last_o), 128'(0));
        chk("rst_ovf", 128'(overflow_o), 128'(0));
        chk("rst_frag", 128'(frag_err_o), 128'(0));
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rv;
        logic         lst;
        logic [31:0]  d;
        logic         rdy;
        logic         ev;
        logic [2:0]   el;
        logic         elast;
        logic [127:0] ed;
    } vec_t;

    vec_t tbl[15];

    localparam logic [127:0] W_T1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] W_A0 = 128'hA0000003_A0000002_A0000001_A0000000;
    localparam logic [127:0] W_A1 = 128'hA0000007_A0000006_A0000005_A0000004;

    initial begin
        // Four beats with last on the fourth: one word, visible for one cycle.
        tbl[0]  = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[3]  = '{1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 3'd1, 1'b1, W_T1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 128'h0};
        // Eight continuous beats with ready low, then drain.
        tbl[5]  = '{1'b1, 1'b0, 32'hA0000000, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'hA0000001, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'hA0000002, 1'b0, 1'b0, 3'd0, 1'b0, 128'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'hA0000003, 1'b0, 1'b1, 3'd1, 1'b0, W_A0};
        tbl[9]  = '{1'b1, 1'b0, 32'hA0000004, 1'b0, 1'b1, 3'd1, 1'b0, W_A0};
        tbl[10] = '{1'b1, 1'b0, 32'hA0000005, 1'b0, 1'b1, 3'd1, 1'b0, W_A0};
        tbl[11] = '{1'b1, 1'b0, 32'hA0000006, 1'b0, 1'b1, 3'd1, 1'b0, W_A0};
        tbl[12] = '{1'b1, 1'b1, 32'hA0000007, 1'b0, 1'b1, 3'd2, 1'b0, W_A0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, W_A1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 128'h0};

        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rv, tbl[i].lst, tbl[i].d, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 128'(rd_valid_o), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d_level", i), 128'(fifo_level_o), 128'(tbl[i].el));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), rd_data_o, tbl[i].ed);
                chk($sformatf("tbl%0d_last", i), 128'(rd_last_o), 128'(tbl[i].elast));
            end
        end

        // Overflow: five words with ready low, the fifth is lost.
        do_reset();
        for (int w = 0; w < 5; w++)
            for (int k = 0; k < BEATS; k++)
                step(1'b1, 1'b0, 32'hB0000000 | 32'(w << 4) | 32'(k), 1'b0, 1'b0);
        chk("t3_level", 128'(fifo_level_o), 128'(4));
        chk("t3_ovf", 128'(overflow_o), 128'(1));
        chk("t3_head", rd_data_o, 128'hB0000003_B0000002_B0000001_B0000000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_drained", 128'(rd_valid_o), 128'(0));

        // Full FIFO, completing beat coincides with a pop.
        do_reset();
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < BEATS; k++)
                step(1'b1, 1'b0, 32'hC0000000 | 32'(w << 4) | 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'hC0000040 | 32'(k), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hC0000043, 1'b1, 1'b0);
        chk("t4_level", 128'(fifo_level_o), 128'(4));
        chk("t4_ovf", 128'(overflow_o), 128'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_newword", rd_data_o, 128'hC0000043_C0000042_C0000041_C0000040);
        chk("t4_newlast", 128'(rd_last_o), 128'(1));
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Fragment, recovery, clear, and set-wins collision.
        do_reset();
        step(1'b1, 1'b0, 32'hD0000001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hD0000002, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hD0000003, 1'b0, 1'b0);
        chk("t5_frag", 128'(frag_err_o), 128'(1));
        chk("t5_nopush", 128'(fifo_level_o), 128'(0));
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b0, 32'hE0000000 | 32'(k), 1'b0, 1'b0);
        chk("t5_word", rd_data_o, 128'hE0000003_E0000002_E0000001_E0000000);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t5_clr", 128'(frag_err_o), 128'(0));
        step(1'b1, 1'b1, 32'hE0000010, 1'b0, 1'b1);
        chk("t5_setwins", 128'(frag_err_o), 128'(1));
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_clr2", 128'(frag_err_o), 128'(0));

        // Reset mid-burst with words buffered and a flag set.
        do_reset();
        step(1'b1, 1'b1, 32'hF0000000, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 32'hF1000000 | 32'(k), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hF2000000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hF2000001, 1'b0, 1'b0);
        chk("t6_buffered", 128'(fifo_level_o), 128'(2));
        do_reset();
        for (int k = 0; k < BEATS; k++) step(1'b1, 1'b0, 32'h90000000 | 32'(k), 1'b0, 1'b0);
        chk("t6_oneword", 128'(fifo_level_o), 128'(1));
        chk("t6_data", rd_data_o, 128'h90000003_90000002_90000001_90000000);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6_empty", 128'(fifo_level_o), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
